// File: rtl/anim_player_pkg.sv
// Shared constants for the animation player: its own register offsets,
// CONTROL bit positions, the matrix driver address register offsets and a
// helper that maps a programmed interval to the refresh count actually used.
package anim_player_pkg;

  localparam logic [3:0] ANIM_CONTROL  = 4'd0;
  localparam logic [3:0] ANIM_INTERVAL = 4'd1;
  localparam logic [3:0] ANIM_COUNT    = 4'd2;
  localparam logic [3:0] ANIM_BASE_L   = 4'd3;
  localparam logic [3:0] ANIM_BASE_H   = 4'd4;
  localparam logic [3:0] ANIM_STRIDE_L = 4'd5;
  localparam logic [3:0] ANIM_STRIDE_H = 4'd6;
  localparam logic [3:0] ANIM_INDEX    = 4'd7;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_LOOP     = 1;
  localparam int CTRL_BUSY     = 2;
  localparam int CTRL_DONE     = 3;
  localparam int CTRL_PINGPONG = 4;

  // Matrix driver registers holding the displayed frame address.
  localparam logic [15:0] MATRIX_ADDR_L = 16'h0002;
  localparam logic [15:0] MATRIX_ADDR_H = 16'h0003;

  // An interval of zero behaves as one refresh per frame.
  function automatic logic [7:0] eff_interval(input logic [7:0] iv);
    return (iv == 8'd0) ? 8'd1 : iv;
  endfunction

endpackage

// File: rtl/anim_player_wb_byte_writer.sv
// wb_byte_writer: single-write Wishbone master. A start request while idle
// latches address/data and raises cyc/stb/we on the next edge; the cycle is
// held until m_ack_i is sampled high, after which the bus drops.
module wb_byte_writer #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ADDRESS_WIDTH-1:0] m_adr_o,
  output logic [DATA_WIDTH-1:0]    m_dat_o,
  output logic                     m_we_o,
  output logic                     m_stb_o,
  output logic                     m_cyc_o,
  input  logic                     m_ack_i
);

  logic                     r_cyc;
  logic [ADDRESS_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0]    r_dat;

  // Launch a write on start, retire it on the sampled acknowledge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cyc <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
    end else if (r_cyc) begin
      if (m_ack_i) r_cyc <= 1'b0;
    end else if (i_start) begin
      r_cyc <= 1'b1;
      r_adr <= i_addr;
      r_dat <= i_data;
    end
  end

  assign o_busy  = r_cyc;
  assign o_done  = r_cyc & m_ack_i;
  assign m_adr_o = r_adr;
  assign m_dat_o = r_dat;
  assign m_we_o  = r_cyc;
  assign m_stb_o = r_cyc;
  assign m_cyc_o = r_cyc;

endmodule

// File: rtl/anim_player.sv
// anim_player: steps the LED matrix driver through a list of frames, one
// frame every INTERVAL display refreshes, by writing the driver's address
// registers (low byte then high byte) over a Wishbone master port.
// Optional feature macro: ANIM_PINGPONG_EN (bounce between first and last
// frame instead of wrapping/stopping; CONTROL[4] selects it).
module anim_player
  import anim_player_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH       = 16,
  parameter int                       DATA_WIDTH          = 8,
  parameter int                       DATA_BYTES          = 1,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = 'h0020,
  parameter logic [ADDRESS_WIDTH-1:0] MATRIX_BASE_ADDRESS = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  input  logic                     we_i,
  input  logic [DATA_BYTES-1:0]    sel_i,
  input  logic                     stb_i,
  input  logic                     cyc_i,
  input  logic [2:0]               cti_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  output logic                     ack_o,
  output logic [ADDRESS_WIDTH-1:0] m_adr_o,
  output logic [DATA_WIDTH-1:0]    m_dat_o,
  input  logic [DATA_WIDTH-1:0]    m_dat_i,
  output logic                     m_we_o,
  output logic                     m_stb_o,
  output logic                     m_cyc_o,
  output logic [DATA_BYTES-1:0]    m_sel_o,
  output logic [2:0]               m_cti_o,
  input  logic                     m_ack_i,
  input  logic                     frame_complete,
  output logic                     irq_o
);

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_WR_L = 4'b0010;
  localparam logic [3:0] S_WR_H = 4'b0100;
  localparam logic [3:0] S_WAIT = 4'b1000;

  logic [3:0]  r_state;
  logic        r_enable, r_loop, r_done, r_irq, r_ack, r_fc_d;
  logic [7:0]  r_interval, r_count, r_index, r_tick;
  logic [15:0] r_base, r_stride, r_cur_addr;
  logic        w_pingpong;

  logic                     w_sel, w_wr, w_ctrl_wr, w_fc_rise, w_busy;
  logic                     w_start, w_wr_busy, w_wr_done;
  logic [8:0]               w_next;
  logic [ADDRESS_WIDTH-1:0] w_wr_addr;
  logic [7:0]               w_wr_data;
  logic [7:0]               w_rd;
  logic                     w_unused_ok;

`ifdef ANIM_PINGPONG_EN
  logic r_pingpong, r_dir;
  assign w_pingpong = r_pingpong;
`else
  assign w_pingpong = 1'b0;
`endif

  // Slave decode: 16-byte window, only offsets 0..7 respond.
  assign w_sel     = cyc_i & stb_i & (adr_i[3:0] < 4'd8) &
                     ((adr_i & {{(ADDRESS_WIDTH-4){1'b1}}, 4'h0}) == BASE_ADDRESS);
  assign w_wr      = w_sel & we_i & ~r_ack;
  assign w_ctrl_wr = w_wr & (adr_i[3:0] == ANIM_CONTROL);
  assign w_fc_rise = frame_complete & ~r_fc_d;
  assign w_busy    = (r_state != S_IDLE);
  assign w_next    = {1'b0, r_index} + 9'd1;

  // The shared writer is (re)started whenever a write state has no cycle out.
  assign w_start   = ((r_state == S_WR_L) | (r_state == S_WR_H)) & ~w_wr_busy;
  assign w_wr_addr = (r_state == S_WR_L) ? MATRIX_BASE_ADDRESS + ADDRESS_WIDTH'(MATRIX_ADDR_L)
                                         : MATRIX_BASE_ADDRESS + ADDRESS_WIDTH'(MATRIX_ADDR_H);
  assign w_wr_data = (r_state == S_WR_L) ? r_cur_addr[7:0] : r_cur_addr[15:8];

  wb_byte_writer #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_writer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_start(w_start),
    .i_addr (w_wr_addr),
    .i_data (DATA_WIDTH'(w_wr_data)),
    .o_busy (w_wr_busy),
    .o_done (w_wr_done),
    .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o),
    .m_we_o (m_we_o),
    .m_stb_o(m_stb_o),
    .m_cyc_o(m_cyc_o),
    .m_ack_i(m_ack_i)
  );

  // Combinational register read-back; zero when the window is not selected.
  always_comb begin
    w_rd = 8'h00;
    case (adr_i[3:0])
      ANIM_CONTROL:  w_rd = {3'b000, w_pingpong, r_done, w_busy, r_loop, r_enable};
      ANIM_INTERVAL: w_rd = r_interval;
      ANIM_COUNT:    w_rd = r_count;
      ANIM_BASE_L:   w_rd = r_base[7:0];
      ANIM_BASE_H:   w_rd = r_base[15:8];
      ANIM_STRIDE_L: w_rd = r_stride[7:0];
      ANIM_STRIDE_H: w_rd = r_stride[15:8];
      ANIM_INDEX:    w_rd = r_index;
      default:       w_rd = 8'h00;
    endcase
    if (!w_sel) w_rd = 8'h00;
  end

  // Register writes followed by the sequencer; later assignments win, so a
  // sequence end may clear enable only when software is not writing CONTROL.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_enable   <= 1'b0;
      r_loop     <= 1'b0;
      r_done     <= 1'b0;
      r_irq      <= 1'b0;
      r_ack      <= 1'b0;
      r_fc_d     <= 1'b0;
      r_interval <= 8'd1;
      r_count    <= 8'd0;
      r_index    <= 8'd0;
      r_tick     <= 8'd0;
      r_base     <= 16'h0000;
      r_stride   <= 16'h0000;
      r_cur_addr <= 16'h0000;
`ifdef ANIM_PINGPONG_EN
      r_pingpong <= 1'b0;
      r_dir      <= 1'b0;
`endif
    end else begin
      r_ack  <= w_sel & ~r_ack;
      r_fc_d <= frame_complete;
      r_irq  <= 1'b0;

      if (w_wr) begin
        case (adr_i[3:0])
          ANIM_CONTROL: begin
            r_enable <= dat_i[CTRL_ENABLE];
            r_loop   <= dat_i[CTRL_LOOP];
            if (dat_i[CTRL_ENABLE]) r_done <= 1'b0;
`ifdef ANIM_PINGPONG_EN
            r_pingpong <= dat_i[CTRL_PINGPONG];
`endif
          end
          ANIM_INTERVAL: r_interval     <= dat_i[7:0];
          ANIM_COUNT:    r_count        <= dat_i[7:0];
          ANIM_BASE_L:   r_base[7:0]    <= {dat_i[7:1], 1'b0};
          ANIM_BASE_H:   r_base[15:8]   <= dat_i[7:0];
          ANIM_STRIDE_L: r_stride[7:0]  <= dat_i[7:0];
          ANIM_STRIDE_H: r_stride[15:8] <= dat_i[7:0];
          default: ;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (r_enable && (r_count != 8'd0)) begin
            r_index    <= 8'd0;
            r_cur_addr <= r_base;
            r_done     <= 1'b0;
`ifdef ANIM_PINGPONG_EN
            r_dir      <= 1'b0;
`endif
            r_state    <= S_WR_L;
          end
        end
        S_WR_L: begin
          // The high byte always follows, even if enable was just cleared.
          if (w_wr_done) r_state <= S_WR_H;
        end
        S_WR_H: begin
          if (w_wr_done) begin
            r_tick  <= eff_interval(r_interval);
            r_state <= r_enable ? S_WAIT : S_IDLE;
          end
        end
        S_WAIT: begin
          if (!r_enable) begin
            r_state <= S_IDLE;
          end else if (r_tick == 8'd0) begin
            r_state <= S_WR_L;
`ifdef ANIM_PINGPONG_EN
            if (r_pingpong) begin
              if (r_count <= 8'd1) begin
                r_index <= r_index;
              end else if (!r_dir && (w_next < {1'b0, r_count})) begin
                r_index    <= r_index + 8'd1;
                r_cur_addr <= r_cur_addr + r_stride;
              end else if (!r_dir) begin
                r_dir      <= 1'b1;
                r_index    <= r_index - 8'd1;
                r_cur_addr <= r_cur_addr - r_stride;
              end else if (r_index != 8'd0) begin
                r_index    <= r_index - 8'd1;
                r_cur_addr <= r_cur_addr - r_stride;
              end else begin
                r_dir      <= 1'b0;
                r_index    <= r_index + 8'd1;
                r_cur_addr <= r_cur_addr + r_stride;
              end
            end else
`endif
            if (w_next < {1'b0, r_count}) begin
              r_index    <= r_index + 8'd1;
              r_cur_addr <= r_cur_addr + r_stride;
            end else if (r_loop) begin
              r_index    <= 8'd0;
              r_cur_addr <= r_base;
            end else begin
              // Last frame stays on the matrix; signal completion.
              r_done  <= 1'b1;
              r_irq   <= 1'b1;
              r_state <= S_IDLE;
              if (!w_ctrl_wr) r_enable <= 1'b0;
            end
          end else if (w_fc_rise) begin
            r_tick <= r_tick - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dat_o   = DATA_WIDTH'(w_rd);
  assign ack_o   = r_ack;
  assign irq_o   = r_irq;
  assign m_sel_o = '1;
  assign m_cti_o = 3'b000;

  assign w_unused_ok = &{1'b0, cti_i, sel_i, m_dat_i};

endmodule

// File: tb/tb_anim_player.sv
// Bench for anim_player: directed register programming, a Wishbone slave
// model on the master port with a programmable acknowledge delay, and a
// frame-sequence model computing every expected matrix write.
module tb_anim_player;
  import anim_player_pkg::*;

  localparam logic [15:0] SBASE = 16'h0020;
  localparam logic [15:0] MBASE = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] adr_i = '0;
  logic [7:0]  dat_i = '0;
  logic        we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
  logic [0:0]  sel_i = 1'b1;
  logic [2:0]  cti_i = 3'b000;
  logic [7:0]  dat_o;
  logic        ack_o;
  logic [15:0] m_adr_o;
  logic [7:0]  m_dat_o;
  logic [7:0]  m_dat_i = 8'h00;
  logic        m_we_o, m_stb_o, m_cyc_o;
  logic [0:0]  m_sel_o;
  logic [2:0]  m_cti_o;
  logic        m_ack_i = 1'b0;
  logic        fc = 1'b0;
  logic        irq_o;

  always #5 clk = ~clk;

  anim_player #(
    .ADDRESS_WIDTH(16), .DATA_WIDTH(8), .DATA_BYTES(1),
    .BASE_ADDRESS(SBASE), .MATRIX_BASE_ADDRESS(MBASE)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .adr_i(adr_i), .dat_i(dat_i), .we_i(we_i), .sel_i(sel_i),
    .stb_i(stb_i), .cyc_i(cyc_i), .cti_i(cti_i),
    .dat_o(dat_o), .ack_o(ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
    .m_sel_o(m_sel_o), .m_cti_o(m_cti_o), .m_ack_i(m_ack_i),
    .frame_complete(fc), .irq_o(irq_o)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t exp_q[$];

  int ack_delay = 0;
  int wait_cnt  = 0;
  int wr_cnt    = 0;
  int irq_seen  = 0;

  // Sequence model: frame k of a run shows index seq_idx(k) at
  // BASE + index*STRIDE; mode 0 = loop, 1 = stop at end, 2 = ping-pong.
  logic [15:0] mb_base, mb_stride;
  int mb_count, mb_interval, mb_mode, mk, mtick;
  bit mrun = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int seq_idx(input int k);
    int period, p;
    if (mb_mode == 0) return k % mb_count;
    if (mb_mode == 1) return k;
    if (mb_count <= 1) return 0;
    period = 2 * (mb_count - 1);
    p = k % period;
    return (p < mb_count) ? p : period - p;
  endfunction

  function automatic logic [15:0] frame_addr(input int idx);
    return 16'(int'(mb_base) + idx * int'(mb_stride));
  endfunction

  task automatic push_frame(input int idx);
    logic [15:0] a;
    wr_t w;
    a = frame_addr(idx);
    w.a = MBASE + MATRIX_ADDR_L; w.d = a[7:0];  exp_q.push_back(w);
    w.a = MBASE + MATRIX_ADDR_H; w.d = a[15:8]; exp_q.push_back(w);
  endtask

  // Master-port slave model and the single compare point for matrix writes.
  always @(negedge clk) begin
    if (irq_o) irq_seen++;
    if (m_ack_i) begin
      m_ack_i = 1'b0;
    end else if (m_cyc_o && m_stb_o) begin
      if (wait_cnt < ack_delay) begin
        wait_cnt++;
      end else begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h, expected none", m_adr_o, m_dat_o);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("mwr_adr", 32'(m_adr_o), 32'(e.a));
          check("mwr_dat", 32'(m_dat_o), 32'(e.d));
          check("mwr_ctl", {29'd0, m_we_o, m_sel_o, |m_cti_o}, 32'h6);
        end
        m_ack_i  = 1'b1;
        wait_cnt = 0;
        wr_cnt++;
      end
    end else if (wait_cnt != 0) begin
      check("mcyc_held", 32'(m_cyc_o & m_stb_o), 32'd1);
      wait_cnt = 0;
    end
  end

  task automatic wb_write(input logic [3:0] off, input logic [7:0] d);
    @(negedge clk);
    adr_i = SBASE | 16'(off); dat_i = d; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk); #1;
    check("slv_wr_ack", 32'(ack_o), 32'd1);
    @(negedge clk);
    we_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] off, output logic [7:0] d);
    @(negedge clk);
    adr_i = SBASE | 16'(off); we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
    #1 d = dat_o;
    @(posedge clk); #1;
    check("slv_rd_ack", 32'(ack_o), 32'd1);
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  task automatic drain();
    n_chk++;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d writes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic start_seq(input logic [15:0] base, input logic [15:0] stride,
                           input int count, input int interval, input int mode,
                           input logic [7:0] ctrl);
    mb_base = base; mb_stride = stride; mb_count = count;
    mb_interval = interval; mb_mode = mode; mk = 0; mtick = 0; mrun = 1'b1;
    wb_write(ANIM_INTERVAL, 8'(interval));
    wb_write(ANIM_COUNT, 8'(count));
    wb_write(ANIM_BASE_L, base[7:0]);
    wb_write(ANIM_BASE_H, base[15:8]);
    wb_write(ANIM_STRIDE_L, stride[7:0]);
    wb_write(ANIM_STRIDE_H, stride[15:8]);
    push_frame(0);
    wb_write(ANIM_CONTROL, ctrl);
    drain();
  endtask

  task automatic pulse();
    if (mrun) begin
      mtick++;
      if (mtick >= ((mb_interval == 0) ? 1 : mb_interval)) begin
        mtick = 0;
        mk++;
        if (mb_mode == 1 && mk >= mb_count) mrun = 1'b0;
        else push_frame(seq_idx(mk));
      end
    end
    fc = 1'b1;
    repeat (3) @(negedge clk);
    fc = 1'b0;
    repeat (3) @(negedge clk);
    drain();
  endtask

  task automatic stop_seq();
    wb_write(ANIM_CONTROL, 8'h00);
    mrun = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    bit any_ack;
    int w0;
`ifdef ANIM_PINGPONG_EN
    int pp_exp[5] = '{1, 2, 1, 0, 1};
`endif

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mcyc", 32'({m_cyc_o, m_stb_o, m_we_o}), 32'd0);
    check("rst_madr", 32'({m_adr_o, m_dat_o}), 32'd0);
    check("rst_irq_ack", 32'({irq_o, ack_o}), 32'd0);
    check("rst_dat_o", 32'(dat_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_read(ANIM_CONTROL, rd);  check("rst_control", 32'(rd), 32'h00);
    wb_read(ANIM_INTERVAL, rd); check("rst_interval", 32'(rd), 32'h01);
    wb_read(ANIM_COUNT, rd);    check("rst_count", 32'(rd), 32'h00);
    wb_read(ANIM_INDEX, rd);    check("rst_index", 32'(rd), 32'h00);

    // Unmapped offset: no acknowledge, read data stays zero
    @(negedge clk);
    adr_i = SBASE | 16'h0009; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
    any_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      any_ack = any_ack | ack_o;
    end
    check("bad_off_ack", 32'(any_ack), 32'd0);
    check("bad_off_dat", 32'(dat_o), 32'd0);
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0;

    // BASE_L bit 0 is not stored
    wb_write(ANIM_BASE_L, 8'h41);
    wb_read(ANIM_BASE_L, rd); check("base_l_bit0", 32'(rd), 32'h40);

    // Pin the model against hand-computed frame addresses
    mb_base = 16'h8000; mb_stride = 16'h0240; mb_count = 3; mb_mode = 0;
    check("model_f1", 32'(frame_addr(seq_idx(1))), 32'h8240);
    check("model_f2", 32'(frame_addr(seq_idx(2))), 32'h8480);
    check("model_f3", 32'(frame_addr(seq_idx(3))), 32'h8000);
    mb_mode = 2;
    check("model_pp5", 32'(seq_idx(5)), 32'd1);
    check("model_pp3", 32'(seq_idx(3)), 32'd1);

    // Looping sequence, two refreshes per frame
    start_seq(16'h8000, 16'h0240, 3, 2, 0, 8'h03);
    repeat (8) pulse();
    wb_read(ANIM_INDEX, rd); check("loop_index", 32'(rd), 32'd1);
    stop_seq();
    wb_read(ANIM_CONTROL, rd); check("loop_stopped", 32'(rd), 32'h00);

    // One-shot sequence: single irq, done set, no writes after the end
    irq_seen = 0;
    start_seq(16'h8000, 16'h0240, 3, 2, 1, 8'h01);
    repeat (8) pulse();
    check("oneshot_irq", 32'(irq_seen), 32'd1);
    wb_read(ANIM_CONTROL, rd); check("oneshot_control", 32'(rd), 32'h08);
    wb_read(ANIM_INDEX, rd);   check("oneshot_index", 32'(rd), 32'd2);

    // Slow master-side slave; enabling again clears done
    ack_delay = 10;
    start_seq(16'h1000, 16'h0010, 2, 1, 0, 8'h03);
    wb_read(ANIM_CONTROL, rd); check("done_cleared", 32'(rd & 8'h08), 32'h00);
    repeat (2) pulse();
    stop_seq();

    // Enable cleared between the low-byte and high-byte writes
    w0 = wr_cnt;
    mb_base = 16'h2000; mb_stride = 16'h0100; mb_count = 3; mb_interval = 1;
    mb_mode = 0; mk = 0; mtick = 0;
    wb_write(ANIM_INTERVAL, 8'd1);
    wb_write(ANIM_COUNT, 8'd3);
    wb_write(ANIM_BASE_L, 8'h00);
    wb_write(ANIM_BASE_H, 8'h20);
    wb_write(ANIM_STRIDE_L, 8'h00);
    wb_write(ANIM_STRIDE_H, 8'h01);
    push_frame(0);
    w0 = wr_cnt;
    wb_write(ANIM_CONTROL, 8'h03);
    n_chk++;
    for (int i = 0; i < 200 && wr_cnt < w0 + 1; i++) @(negedge clk);
    if (wr_cnt < w0 + 1) begin
      n_err++;
      $display("FAIL wait_l_write: got %0d writes, expected %0d", wr_cnt - w0, 1);
    end
    wb_write(ANIM_CONTROL, 8'h00);
    mrun = 1'b0;
    drain();
    wb_read(ANIM_CONTROL, rd); check("abort_idle", 32'(rd), 32'h00);
    repeat (2) pulse();
    ack_delay = 0;

    // Interval zero: every refresh edge advances
    start_seq(16'h3000, 16'h0002, 2, 0, 0, 8'h03);
    for (int i = 0; i < 4; i++) begin
      pulse();
      wb_read(ANIM_INDEX, rd); check("iv0_index", 32'(rd), 32'(seq_idx(mk)));
    end
    stop_seq();

`ifdef ANIM_PINGPONG_EN
    // Ping-pong over three frames
    start_seq(16'h4000, 16'h0008, 3, 1, 2, 8'h11);
    for (int i = 0; i < 5; i++) begin
      pulse();
      wb_read(ANIM_INDEX, rd); check("pp_index", 32'(rd), 32'(pp_exp[i]));
    end
    stop_seq();
`else
    // Without ping-pong support CONTROL[4] is not writable
    wb_write(ANIM_CONTROL, 8'h10);
    wb_read(ANIM_CONTROL, rd); check("pp_absent", 32'(rd), 32'h00);
`endif

    check("no_extra_writes", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
